// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I data memory:
// width codes, FSM states, default depth and fault check.
package riscv_mem_pkg;

  localparam int DEPTH_DEF = 256;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic acc_err(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] last
  );
    logic bad_f3;
    logic misal;
    if (we) bad_f3 = (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    else    bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    misal = ((f3 == F3_H || f3 == F3_HU) && addr[0])
         || ((f3 == F3_W) && (addr[1:0] != 2'b00));
    return bad_f3 || misal || (addr > last);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a word and
// sign- or zero-extends it according to funct3.
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[8*lane_i +: 8];
    h = lane_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = '0;
    unique case (funct3_i)
      F3_B:    result_o = {{24{b[7]}}, b};
      F3_H:    result_o = {{16{h[15]}}, h};
      F3_W:    result_o = word_i;
      F3_BU:   result_o = {24'd0, b};
      F3_HU:   result_o = {16'd0, h};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Single-port RV32I data memory: one access per two
// cycles, response one cycle after acceptance.
module data_memory
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LAST = 32'(DEPTH * 4 - 1);

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Contents are not reset; they start at zero.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic          accept;
  logic          busy;
  logic          err;
  logic          commit;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [31:0]   ext;
  logic [3:0]    be;
  logic [31:0]   wd;

  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == BUSY);
  assign idx       = addr_q[AW+1:2];
  assign lane      = addr_q[1:0];
  assign err       = acc_err(we_q, f3_q, addr_q, LAST);
  assign word      = mem_q[idx];
  assign commit    = busy && we_q && !err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    wd = wdata_q;
    unique case (f3_q)
      F3_B: begin
        be = 4'b0001 << lane;
        wd = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  load_extend u_ext (
    .word_i   (word),
    .lane_i   (lane),
    .funct3_i (f3_q),
    .result_o (ext)
  );

  assign rsp_valid = busy;
  assign rsp_err   = busy && err;
  assign rsp_rdata = (busy && !we_q && !err) ? ext : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed vector bench for data_memory.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int passed = 0;

  data_memory #(.DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic e);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a;
    v.wdata = wd; v.rdata = rd; v.err = e;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic access(input string name, input vec_t v);
    wait_ready(name);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_rdata"}, rsp_rdata, v.rdata);
    chk({name, "_err"}, 32'(rsp_err), 32'(v.err));
  endtask

  initial begin
    // Functional loads/stores and byte-lane behaviour
    vecs.push_back(mk(1, 3'd2, 32'd100, 32'h00000004, 32'h0, 0));
    vecs.push_back(mk(0, 3'd2, 32'd100, 32'h0, 32'h00000004, 0));
    vecs.push_back(mk(1, 3'd2, 32'd104, 32'h8081F0FE, 32'h0, 0));
    vecs.push_back(mk(0, 3'd0, 32'd104, 32'h0, 32'hFFFFFFFE, 0));
    vecs.push_back(mk(0, 3'd4, 32'd104, 32'h0, 32'h000000FE, 0));
    vecs.push_back(mk(0, 3'd1, 32'd106, 32'h0, 32'hFFFF8081, 0));
    vecs.push_back(mk(0, 3'd5, 32'd106, 32'h0, 32'h00008081, 0));
    vecs.push_back(mk(0, 3'd0, 32'd107, 32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 3'd4, 32'd105, 32'h0, 32'h000000F0, 0));
    vecs.push_back(mk(0, 3'd1, 32'd104, 32'h0, 32'hFFFFF0FE, 0));
    vecs.push_back(mk(1, 3'd2, 32'd108, 32'h11223344, 32'h0, 0));
    vecs.push_back(mk(1, 3'd1, 32'd110, 32'hFFFFABCD, 32'h0, 0));
    vecs.push_back(mk(0, 3'd2, 32'd108, 32'h0, 32'hABCD3344, 0));
    vecs.push_back(mk(1, 3'd0, 32'd109, 32'h00000055, 32'h0, 0));
    vecs.push_back(mk(0, 3'd2, 32'd108, 32'h0, 32'hABCD5544, 0));
    // Faults
    vecs.push_back(mk(0, 3'd2, 32'd102, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 3'd1, 32'd103, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 3'd2, 32'd1024, 32'h12345678, 32'h0, 1));
    vecs.push_back(mk(0, 3'd2, 32'd100, 32'h0, 32'h00000004, 0));
    vecs.push_back(mk(0, 3'd3, 32'd100, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 3'd4, 32'd100, 32'h99999999, 32'h0, 1));
    vecs.push_back(mk(1, 3'd1, 32'd101, 32'h77777777, 32'h0, 1));
    vecs.push_back(mk(0, 3'd2, 32'd100, 32'h0, 32'h00000004, 0));
    // Top of memory
    vecs.push_back(mk(1, 3'd0, 32'd1023, 32'hFFFFFFAA, 32'h0, 0));
    vecs.push_back(mk(0, 3'd2, 32'd1020, 32'h0, 32'hAA000000, 0));
    vecs.push_back(mk(0, 3'd0, 32'd1024, 32'h0, 32'h0, 1));

    // Reset state
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) access($sformatf("v%0d", i), vecs[i]);

    // Back-to-back: req_valid held high
    wait_ready("b2b");
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'd100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready%0d", k), 32'(req_ready), 32'(k % 2 == 0));
      chk($sformatf("b2b_valid%0d", k), 32'(rsp_valid), 32'(k % 2 == 1));
      if (k % 2 == 1)
        chk($sformatf("b2b_rdata%0d", k), rsp_rdata, 32'h4);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_idle_valid", 32'(rsp_valid), 32'd0);

    // Reset during a pending store
    wait_ready("rstbusy");
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'd200;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rstbusy_valid", 32'(rsp_valid), 32'd0);
    chk("rstbusy_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rstbusy_valid2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstbusy_valid3", 32'(rsp_valid), 32'd0);
    access("rstbusy_lw", mk(0, 3'd2, 32'd200, 32'h0, 32'h0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the number of 32-bit words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, access request present.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata, output, 32, load result, extended per funct3; 0 for stores and errors.
REQ-012 SHALL have port rsp_err, output, 1, access faulted; valid only with rsp_valid.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY; req_ready = 1 exactly in IDLE.
REQ-014 SHALL accept a request when req_valid && req_ready, latch we/funct3/addr/wdata, and go to BUSY on that edge.
REQ-015 SHALL, in BUSY, drive rsp_valid = 1 for exactly one cycle with rsp_rdata/rsp_err, then return to IDLE; latency 1 cycle, max one access per 2 cycles.
REQ-016 SHALL ignore req_* while in BUSY; req_valid without acceptance has no effect.
REQ-017 SHALL compute word index addr[log2(DEPTH)+1:2] and byte lane addr[1:0].
REQ-018 SHALL, for stores, commit to the array at the edge that ends BUSY: SB writes wdata[7:0] to lane addr[1:0]; SH writes wdata[15:0] to bytes addr[1]*2..+1; SW writes all 4 bytes; other lanes unchanged.
REQ-019 SHALL, for loads, read the array combinationally in BUSY: LB/LH sign-extend, LBU/LHU zero-extend, LW returns word unmodified.
REQ-020 SHALL flag rsp_err = 1 on: H/HU with addr[0] = 1; W with addr[1:0] != 0; address beyond DEPTH*4-1; load funct3 in {3,6,7}; store funct3 not in {0,1,2}.
REQ-021 SHALL on error perform no array write and drive rsp_rdata = 0.
REQ-022 SHALL present a load of a location written by the immediately preceding store with the new value (store commits before next acceptance).

Reset
REQ-023 SHALL, while rst_n = 0, force state IDLE, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, req_ready = 0 only during reset assertion, 1 in the first cycle after release.
REQ-024 SHALL, on reset asserted during BUSY, abandon the pending access: no store commit, no response.
REQ-025 SHALL NOT reset the storage array; array initialises to all zeros at time zero.

Structure
REQ-026 SHALL place funct3 width codes, the FSM state enum and the default DEPTH in shared package riscv_mem_pkg.
REQ-027 SHALL factor lane select plus sign/zero extension into combinational sub-module load_extend (inputs word, addr[1:0], funct3; output 32-bit result).

Verification
REQ-028 SW 0x00000004 @100, then LW @100 -> rsp_valid one cycle after each accept, rsp_rdata = 0x00000004, rsp_err = 0.
REQ-029 SW 0x8081F0FE @104; LB @104 -> 0xFFFFFFFE; LBU @104 -> 0x000000FE; LH @106 -> 0xFFFF8081; LHU @106 -> 0x00008081.
REQ-030 SH 0xABCD @110 after SW 0x11223344 @108; LW @108 -> 0xABCD3344; SB 0x55 @109; LW @108 -> 0xABCD5544.
REQ-031 LW @102, LH @103, SW @1024 -> each rsp_err = 1, rsp_rdata = 0; a following LW @100 shows the word unchanged.
REQ-032 req_valid held high continuously -> req_ready toggles 1/0, accepts every 2nd cycle, rsp_valid on alternate cycles.
REQ-033 Accept SW 0xDEADBEEF @200, assert rst_n = 0 during BUSY -> no rsp_valid; after release LW @200 -> 0x00000000.
